// File: rtl/hp48_bus_ram_pkg.sv
// Shared definitions for the Saturn-bus nibble RAM slave: bus command codes,
// address width and the CONFIGURE size-operand check.
package hp48_bus_ram_pkg;

  localparam int ADDR_W = 20;

  typedef enum logic [3:0] {
    BUSCMD_NOP         = 4'h0,
    BUSCMD_PC_READ     = 4'h1,
    BUSCMD_DP_READ     = 4'h2,
    BUSCMD_PC_WRITE    = 4'h3,
    BUSCMD_DP_WRITE    = 4'h4,
    BUSCMD_LOAD_PC     = 4'h5,
    BUSCMD_LOAD_DP     = 4'h6,
    BUSCMD_CONFIGURE   = 4'h7,
    BUSCMD_UNCONFIGURE = 4'h8,
    BUSCMD_RESET       = 4'h9
  } buscmd_e;

  // The size operand is the two's complement of the block length; the length
  // must be a nonzero power of two that fits in the physical array.
  function automatic logic size_ok(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W:0]   depth);
    logic [ADDR_W:0] len;
    len = {1'b0, (~addr + 20'd1)};
    return (len != '0) && ((len & (len - 21'd1)) == '0) && (len <= depth);
  endfunction

endpackage

// File: rtl/hp48_bus_ram_array.sv
// Nibble storage: synchronous write, registered read port. Only the read
// register is reset; the array contents survive reset.
module nibble_ram_array
  import hp48_bus_ram_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int INIT_ZERO = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    wdata,
  output logic [3:0]    rdata
);

  generate
    if (INIT_ZERO != 0) begin : g_zero
      logic [3:0] mem [DEPTH] = '{default: 4'h0};
      always_ff @(posedge clk) if (we) mem[addr] <= wdata;
      always_ff @(posedge clk or posedge rst)
        if (rst)     rdata <= 4'h0;
        else if (re) rdata <= mem[addr];
    end else begin : g_nozero
      logic [3:0] mem [DEPTH];
      always_ff @(posedge clk) if (we) mem[addr] <= wdata;
      always_ff @(posedge clk or posedge rst)
        if (rst)     rdata <= 4'h0;
        else if (re) rdata <= mem[addr];
    end
  endgenerate

endmodule

// File: rtl/hp48_bus_ram.sv
// Configurable nibble RAM slave on the Saturn bus: two-step CONFIGURE,
// UNCONFIGURE, PC/DP pointers, optional read-only mode, sticky error.
module hp48_bus_ram
  import hp48_bus_ram_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int READ_ONLY = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        command,
  input  logic [3:0]        nibble_in,
  input  logic              daisy_in,
  output logic [3:0]        nibble_out,
  output logic              active,
  output logic              configured,
  output logic              error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_UNCONF     = 2'd0,
    ST_SIZED      = 2'd1,
    ST_CONFIGURED = 2'd2
  } cfg_state_e;

  cfg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, dp_q, dp_d;
  logic [ADDR_W-1:0] mask_q, mask_d, base_q, base_d;
  logic              err_q, err_d;

  logic              is_pc, rd_cmd, wr_cmd, hit;
  logic [ADDR_W-1:0] ptr;
  logic [AW-1:0]     index;

  assign is_pc  = (command == BUSCMD_PC_READ) || (command == BUSCMD_PC_WRITE);
  assign rd_cmd = (command == BUSCMD_PC_READ) || (command == BUSCMD_DP_READ);
  assign wr_cmd = (command == BUSCMD_PC_WRITE) || (command == BUSCMD_DP_WRITE);
  assign ptr    = is_pc ? pc_q : dp_q;
  assign hit    = (state_q == ST_CONFIGURED) && ((ptr & mask_q) == base_q);
  assign index  = ptr[AW-1:0] & ~mask_q[AW-1:0];

  // A frozen (error) block must never own the bus or touch memory.
  assign active = ~err_q & hit & (rd_cmd | (wr_cmd & (READ_ONLY == 0)));

  assign configured = (state_q == ST_CONFIGURED);
  assign error      = err_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dp_d    = dp_q;
    mask_d  = mask_q;
    base_d  = base_q;
    err_d   = err_q;
    if (!err_q) begin
      case (command)
        BUSCMD_NOP: ;
        BUSCMD_PC_READ, BUSCMD_PC_WRITE: pc_d = pc_q + 20'd1;
        BUSCMD_DP_READ, BUSCMD_DP_WRITE: dp_d = dp_q + 20'd1;
        BUSCMD_LOAD_PC: pc_d = address;
        BUSCMD_LOAD_DP: dp_d = address;
        BUSCMD_CONFIGURE: begin
          if (daisy_in) begin
            case (state_q)
              ST_UNCONF: begin
                if (size_ok(address, 21'(DEPTH))) begin
                  mask_d  = address;
                  state_d = ST_SIZED;
                end else begin
                  err_d = 1'b1;
                end
              end
              ST_SIZED: begin
                base_d  = address & mask_q;
                state_d = ST_CONFIGURED;
              end
              default: ;
            endcase
          end
        end
        BUSCMD_UNCONFIGURE: begin
          if (state_q == ST_CONFIGURED && (address & mask_q) == base_q)
            state_d = ST_UNCONF;
        end
        BUSCMD_RESET: state_d = ST_UNCONF;
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_UNCONF;
      pc_q    <= '0;
      dp_q    <= '0;
      mask_q  <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dp_q    <= dp_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      err_q   <= err_d;
    end
  end

  // The array itself ignores reset, so an access overlapping reset is
  // blocked here to keep memory untouched.
  nibble_ram_array #(
    .DEPTH     (DEPTH),
    .INIT_ZERO (INIT_ZERO)
  ) u_array (
    .clk   (clk),
    .rst   (reset),
    .we    (active & wr_cmd & ~reset),
    .re    (active & rd_cmd & ~reset),
    .addr  (index),
    .wdata (nibble_in),
    .rdata (nibble_out)
  );

endmodule
